// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module : fft_pkg
// Brief  : Shared defaults, FSM encoding, address and twiddle helpers for the
//          FFT pair sequencer.
// Rev    : 1.0
// ============================================================================
package fft_pkg;

    localparam int LOG2N_DEF   = 10;
    localparam int TW_W_DEF    = 16;
    localparam int TW_FRAC_DEF = 13;
    localparam int BF_LAT_DEF  = 3;
    localparam int ADDR_MAX_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    // Insert bit_v at position pos of b, shifting the upper bits left by one.
    function automatic logic [ADDR_MAX_W-1:0] insert_bit(
        input logic [ADDR_MAX_W-1:0] b,
        input logic [3:0]            pos,
        input logic                  bit_v
    );
        logic [ADDR_MAX_W-1:0] low_mask;
        low_mask = (ADDR_MAX_W'(1) << pos) - ADDR_MAX_W'(1);
        return ((b & ~low_mask) << 1) | (ADDR_MAX_W'(bit_v) << pos) | (b & low_mask);
    endfunction

    // 2*pi scaled by 2^28; series is evaluated in Q28 and rounded to frac bits.
    localparam longint c_ang_scale = 64'sd1686629713;

    // Real part (cos) or imaginary part (-sin) of W_N^k, elaboration-time only.
    function automatic int twiddle_val(
        input int k,
        input int log2n,
        input int frac,
        input bit want_imag
    );
        longint x, x2, term_c, term_s, acc_c, acc_s, half, sel;
        int     sh;
        x      = (longint'(k) * c_ang_scale) >>> log2n;
        x2     = (x * x) >>> 28;
        acc_c  = 64'sd1 <<< 28;
        term_c = acc_c;
        acc_s  = x;
        term_s = x;
        for (int n = 1; n < 16; n++) begin
            term_c = -(((term_c * x2) >>> 28) / longint'((2*n-1) * (2*n)));
            term_s = -(((term_s * x2) >>> 28) / longint'((2*n) * (2*n+1)));
            acc_c  = acc_c + term_c;
            acc_s  = acc_s + term_s;
        end
        sh   = 28 - frac;
        half = 64'sd1 <<< (sh - 1);
        sel  = want_imag ? -acc_s : acc_c;
        return int'((sel + half) >>> sh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pair_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : fft_pair_sequencer_if
// Brief  : Control, RAM address and twiddle bus of the FFT pair sequencer.
// Rev    : 1.0
// ============================================================================
interface fft_pair_sequencer_if
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int TW_W  = TW_W_DEF
);
    logic                    start;
    logic                    stall;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [LOG2N-1:0]        rd_addr_p;
    logic [LOG2N-1:0]        rd_addr_q;
    logic                    bf_en;
    logic signed [TW_W-1:0]  factor_real;
    logic signed [TW_W-1:0]  factor_imag;
    logic                    wr_en;
    logic [LOG2N-1:0]        wr_addr_p;
    logic [LOG2N-1:0]        wr_addr_q;
    logic [3:0]              stage;

    modport master (
        input  start, stall,
        output busy, done, rd_en, rd_addr_p, rd_addr_q, bf_en,
               factor_real, factor_imag, wr_en, wr_addr_p, wr_addr_q, stage
    );

    modport slave (
        output start, stall,
        input  busy, done, rd_en, rd_addr_p, rd_addr_q, bf_en,
               factor_real, factor_imag, wr_en, wr_addr_p, wr_addr_q, stage
    );
endinterface
`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
`default_nettype none
// ============================================================================
// Module : fft_twiddle_rom
// Brief  : N/2-entry twiddle table with registered output (aligns with bf_en).
// Rev    : 1.0
// ============================================================================
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int LOG2N   = LOG2N_DEF,
    parameter int TW_W    = TW_W_DEF,
    parameter int TW_FRAC = TW_FRAC_DEF
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   en_i,
    input  wire logic [LOG2N-2:0]       k_i,
    output logic signed [TW_W-1:0]      re_o,
    output logic signed [TW_W-1:0]      im_o
);
    localparam int HALF_N = 1 << (LOG2N - 1);

    logic [2*TW_W-1:0]        w_table [HALF_N];
    logic signed [TW_W-1:0]   re_q;
    logic signed [TW_W-1:0]   im_q;

    for (genvar gi = 0; gi < HALF_N; gi++) begin : g_rom
        localparam logic [TW_W-1:0] c_re = TW_W'(twiddle_val(gi, LOG2N, TW_FRAC, 1'b0));
        localparam logic [TW_W-1:0] c_im = TW_W'(twiddle_val(gi, LOG2N, TW_FRAC, 1'b1));
        assign w_table[gi] = {c_re, c_im};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (en_i) begin
            {re_q, im_q} <= w_table[k_i];
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;
endmodule
`default_nettype wire

// File: rtl/fft_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fft_pair_sequencer
// Brief  : Walks all stages of an in-place DIT FFT, one butterfly per cycle.
// Rev    : 1.0
// ============================================================================
module fft_pair_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N   = LOG2N_DEF,
    parameter int TW_W    = TW_W_DEF,
    parameter int TW_FRAC = TW_FRAC_DEF,
    parameter int BF_LAT  = BF_LAT_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fft_pair_sequencer_if.master  bus
);
    localparam int               B_W          = LOG2N - 1;
    localparam int               DLY          = BF_LAT + 1;
    localparam int               CNT_W        = $clog2(BF_LAT + 2);
    localparam logic [B_W-1:0]   c_b_last     = '1;
    localparam logic [3:0]       c_stage_last = 4'(LOG2N - 1);
    localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(BF_LAT);

    fsm_state_e         state_q, state_d;
    logic [3:0]         stage_q, stage_d;
    logic [B_W-1:0]     b_q, b_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic               w_issue;
    logic [LOG2N-1:0]   w_addr_p, w_addr_q;
    logic [B_W-1:0]     w_k_mask, w_k;
    logic [DLY-1:0]     en_sr_q;
    logic [LOG2N-1:0]   p_sr_q [DLY];
    logic [LOG2N-1:0]   q_sr_q [DLY];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            b_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            b_q     <= b_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        drain_d = drain_q;
        w_issue = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    b_d     = '0;
                end
            end
            ST_ISSUE: begin
                drain_d = '0;
                if (!bus.stall) begin
                    w_issue = 1'b1;
                    b_d     = b_q + 1'b1;
                    if (b_q == c_b_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            // Drain lets the last write of this stage land before the next stage reads.
            ST_DRAIN: begin
                if (drain_q == c_drain_last) begin
                    if (stage_q == c_stage_last) begin
                        state_d = ST_DONE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        b_d     = '0;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_addr_p = LOG2N'(insert_bit(ADDR_MAX_W'(b_q), stage_q, 1'b0));
        w_addr_q = LOG2N'(insert_bit(ADDR_MAX_W'(b_q), stage_q, 1'b1));
        w_k_mask = B_W'((32'd1 << stage_q) - 32'd1);
        w_k      = (b_q & w_k_mask) << (B_W - int'(stage_q));
    end

    // Write-back pipeline advances every cycle so stall bubbles flow through.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_sr_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                p_sr_q[i] <= '0;
                q_sr_q[i] <= '0;
            end
        end else begin
            en_sr_q   <= {en_sr_q[DLY-2:0], w_issue};
            p_sr_q[0] <= bus.rd_addr_p;
            q_sr_q[0] <= bus.rd_addr_q;
            for (int i = 1; i < DLY; i++) begin
                p_sr_q[i] <= p_sr_q[i-1];
                q_sr_q[i] <= q_sr_q[i-1];
            end
        end
    end

    fft_twiddle_rom #(
        .LOG2N   (LOG2N),
        .TW_W    (TW_W),
        .TW_FRAC (TW_FRAC)
    ) u_twiddle_rom (
        .clk  (clk),
        .rst  (rst),
        .en_i (w_issue),
        .k_i  (w_k),
        .re_o (bus.factor_real),
        .im_o (bus.factor_imag)
    );

    assign bus.busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.stage     = stage_q;
    assign bus.rd_en     = w_issue;
    assign bus.rd_addr_p = w_issue ? w_addr_p : '0;
    assign bus.rd_addr_q = w_issue ? w_addr_q : '0;
    assign bus.bf_en     = en_sr_q[0];
    assign bus.wr_en     = en_sr_q[DLY-1];
    assign bus.wr_addr_p = p_sr_q[DLY-1];
    assign bus.wr_addr_q = q_sr_q[DLY-1];
endmodule
`default_nettype wire

// File: tb/tb_fft_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_pair_sequencer
// Brief  : Scoreboard bench for fft_pair_sequencer at LOG2N=3.
// Rev    : 1.0
// ============================================================================
module tb_fft_pair_sequencer;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_pair_sequencer_if #(.LOG2N(3), .TW_W(16)) bus ();

    fft_pair_sequencer #(
        .LOG2N   (3),
        .TW_W    (16),
        .TW_FRAC (13),
        .BF_LAT  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t rd_q[$];
    ev_t bf_q[$];
    ev_t wr_q[$];
    int  done_q[$];
    int  exp_busy_lo = 1;
    int  exp_busy_hi = 0;

    // Issue cycles relative to start, without stall and with stall in cycles 2-3.
    int iss_ns [12] = '{1, 2, 3, 4, 9, 10, 11, 12, 17, 18, 19, 20};
    int iss_st [12] = '{1, 4, 5, 6, 11, 12, 13, 14, 19, 20, 21, 22};
    int exp_p  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_q  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_re [12] = '{8192, 8192, 8192, 8192, 8192, 0, 8192, 0, 8192, 5793, 0, -5793};
    int exp_im [12] = '{0, 0, 0, 0, 0, -8192, 0, -8192, 0, -5793, -8192, -5793};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected events whenever the DUT presents one.
    initial begin
        ev_t e;
        int  d;
        forever begin
            @(negedge clk);
            #2;
            check("busy", int'(bus.busy), int'(cyc >= exp_busy_lo && cyc <= exp_busy_hi));
            if (bus.rd_en) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_addr_p", int'(bus.rd_addr_p), e.a);
                    check("rd_addr_q", int'(bus.rd_addr_q), e.b);
                end
            end
            if (bus.bf_en) begin
                if (bf_q.size() == 0) check("bf_unexpected", 1, 0);
                else begin
                    e = bf_q.pop_front();
                    check("bf_cycle", cyc, e.cyc);
                    check("factor_real", int'(bus.factor_real), e.a);
                    check("factor_imag", int'(bus.factor_imag), e.b);
                end
            end
            if (bus.wr_en) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr_p", int'(bus.wr_addr_p), e.a);
                    check("wr_addr_q", int'(bus.wr_addr_q), e.b);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d);
                end
            end
        end
    end

    task automatic run(input bit stalled, input int n_rd, input int n_bf, input int n_wr,
                       input int busy_end, input int done_off, input int stall_a,
                       input int stall_b, input int start_a, input int start_b,
                       input int rst_at);
        int  base;
        int  t;
        ev_t e;
        base = cyc;
        for (int i = 0; i < 12; i++) begin
            t = stalled ? iss_st[i] : iss_ns[i];
            if (i < n_rd) begin
                e.cyc = base + t;     e.a = exp_p[i];  e.b = exp_q[i];  rd_q.push_back(e);
            end
            if (i < n_bf) begin
                e.cyc = base + t + 1; e.a = exp_re[i]; e.b = exp_im[i]; bf_q.push_back(e);
            end
            if (i < n_wr) begin
                e.cyc = base + t + 4; e.a = exp_p[i];  e.b = exp_q[i];  wr_q.push_back(e);
            end
        end
        if (done_off > 0) done_q.push_back(base + done_off);
        exp_busy_lo = base + 1;
        exp_busy_hi = base + busy_end;
        bus.start = 1'b1;
        for (int c = 1; c < 36; c++) begin
            @(negedge clk);
            bus.start = (c == start_a) || (c == start_b);
            bus.stall = (c == stall_a) || (c == stall_b);
            rst       = (c == rst_at);
            if (rst_at > 0 && c == rst_at + 1) begin
                #3;
                check("post_rst_busy", int'(bus.busy), 0);
                check("post_rst_rd_en", int'(bus.rd_en), 0);
                check("post_rst_bf_en", int'(bus.bf_en), 0);
                check("post_rst_wr_en", int'(bus.wr_en), 0);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.stall = 1'b0;
        check("rd_leftover", rd_q.size(), 0);
        check("bf_leftover", bf_q.size(), 0);
        check("wr_leftover", wr_q.size(), 0);
        check("done_leftover", done_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_rd_en", int'(bus.rd_en), 0);
        check("rst_rd_addr_q", int'(bus.rd_addr_q), 0);
        check("rst_bf_en", int'(bus.bf_en), 0);
        check("rst_factor_real", int'(bus.factor_real), 0);
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_stage", int'(bus.stage), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // Plain run.
        run(1'b0, 12, 12, 12, 24, 25, -1, -1, -1, -1, -1);
        // Stall in cycles 2-3 of stage 0.
        run(1'b1, 12, 12, 12, 26, 27, 2, 3, -1, -1, -1);
        // Reset in cycle 10 aborts the run.
        run(1'b0, 6, 5, 4, 10, 0, -1, -1, -1, -1, 10);
        // Fresh start after abort.
        run(1'b0, 12, 12, 12, 24, 25, -1, -1, -1, -1, -1);
        // Extra start pulses while busy and in DONE.
        run(1'b0, 12, 12, 12, 24, 25, -1, -1, 5, 25, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
